// File: rtl/upsample_stream_nd.sv
// upsample_stream_nd: streaming zero-insertion upsampler, optional frame-last flag (UPSAMPLE_FRAME_LAST_EN)
module upsample_stream_nd #(
    parameter int DATA_WIDTH = 16,
    parameter int IN_WIDTH   = 13,
    parameter int IN_HEIGHT  = 13,
    parameter int CHANNELS   = 1,
    parameter int STRIDE     = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  ready_in,
    output logic                  valid_out,
    output logic [DATA_WIDTH-1:0] data_out,
    input  logic                  ready_out
`ifdef UPSAMPLE_FRAME_LAST_EN
    ,
    output logic                  last_out
`endif
);
    localparam int ZN = (STRIDE - 1) * CHANNELS;
    localparam int PN = (STRIDE - 1) * IN_WIDTH * STRIDE * CHANNELS;
    localparam int CW = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
    localparam int XW = IN_WIDTH > 1 ? $clog2(IN_WIDTH) : 1;
    localparam int YW = IN_HEIGHT > 1 ? $clog2(IN_HEIGHT) : 1;
    localparam int ZW = ZN > 1 ? $clog2(ZN) : 1;
    localparam int PW = PN > 1 ? $clog2(PN) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(CHANNELS - 1);
    localparam logic [XW-1:0] X_LAST = XW'(IN_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IN_HEIGHT - 1);
    localparam logic [ZW-1:0] Z_LAST = ZW'(ZN > 0 ? ZN - 1 : 0);
    localparam logic [PW-1:0] P_LAST = PW'(PN > 0 ? PN - 1 : 0);
    localparam logic [1:0] S_PIXEL = 2'd0;
    localparam logic [1:0] S_HZERO = 2'd1;
    localparam logic [1:0] S_VPAD  = 2'd2;

    logic [1:0]            state, nxt_state;
    logic [CW-1:0]         ch_cnt, nxt_ch;
    logic [XW-1:0]         x_cnt, nxt_x;
    logic [YW-1:0]         y_cnt, nxt_y, y_adv;
    logic [ZW-1:0]         zero_cnt, nxt_zero;
    logic [PW-1:0]         pad_cnt, nxt_pad;
    logic                  nxt_valid;
    logic [DATA_WIDTH-1:0] nxt_data;
    logic                  free, row_end;

    assign free     = !valid_out || ready_out;
    assign ready_in = (state == S_PIXEL) && free;
    assign row_end  = x_cnt == X_LAST;
    assign y_adv    = (y_cnt == Y_LAST) ? '0 : y_cnt + 1'b1;

    // next beat and counter values, applied only when the output slot is free
    always_comb begin
        nxt_state = state;
        nxt_ch    = ch_cnt;
        nxt_x     = x_cnt;
        nxt_y     = y_cnt;
        nxt_zero  = zero_cnt;
        nxt_pad   = pad_cnt;
        nxt_valid = 1'b0;
        nxt_data  = '0;
        case (state)
            S_PIXEL: begin
                if (valid_in) begin
                    nxt_valid = 1'b1;
                    nxt_data  = data_in;
                    if (ch_cnt == C_LAST) begin
                        nxt_ch = '0;
                        if (STRIDE > 1) begin
                            nxt_state = S_HZERO;
                        end else begin
                            nxt_x = row_end ? '0 : x_cnt + 1'b1;
                            nxt_y = row_end ? y_adv : y_cnt;
                        end
                    end else begin
                        nxt_ch = ch_cnt + 1'b1;
                    end
                end
            end
            S_HZERO: begin
                nxt_valid = 1'b1;
                if (zero_cnt == Z_LAST) begin
                    nxt_zero  = '0;
                    nxt_x     = row_end ? '0 : x_cnt + 1'b1;
                    nxt_state = row_end ? S_VPAD : S_PIXEL;
                end else begin
                    nxt_zero = zero_cnt + 1'b1;
                end
            end
            S_VPAD: begin
                nxt_valid = 1'b1;
                if (pad_cnt == P_LAST) begin
                    nxt_pad   = '0;
                    nxt_y     = y_adv;
                    nxt_state = S_PIXEL;
                end else begin
                    nxt_pad = pad_cnt + 1'b1;
                end
            end
            default: nxt_state = S_PIXEL;
        endcase
    end

    // state, counters and output register; everything holds while the slot is occupied
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_PIXEL;
            ch_cnt    <= '0;
            x_cnt     <= '0;
            y_cnt     <= '0;
            zero_cnt  <= '0;
            pad_cnt   <= '0;
            valid_out <= 1'b0;
            data_out  <= '0;
        end else if (free) begin
            state     <= nxt_state;
            ch_cnt    <= nxt_ch;
            x_cnt     <= nxt_x;
            y_cnt     <= nxt_y;
            zero_cnt  <= nxt_zero;
            pad_cnt   <= nxt_pad;
            valid_out <= nxt_valid;
            data_out  <= nxt_data;
        end
    end

`ifdef UPSAMPLE_FRAME_LAST_EN
    logic last_beat;

    // final beat of the frame: last pad zero, or last channel of last pixel without padding
    always_comb begin
        last_beat = (STRIDE > 1)
            ? (state == S_VPAD && pad_cnt == P_LAST && y_cnt == Y_LAST)
            : (state == S_PIXEL && valid_in && ch_cnt == C_LAST && row_end && y_cnt == Y_LAST);
    end

    // frame-last flag registered alongside data_out
    always_ff @(posedge clk) begin
        if (!rst_n) last_out <= 1'b0;
        else if (free) last_out <= last_beat;
    end
`endif
endmodule

// File: tb/tb_upsample_stream_nd.sv
// tb_upsample_stream_nd: scoreboard bench for three upsampler configurations sharing one stimulus bus
module tb_upsample_stream_nd;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, valid_in, ready_out;
    logic [15:0] data_in;
    logic        rdy_a, rdy_b, rdy_c, va, vb, vc;
    logic [15:0] da, db, dc;
    logic        la, lb, lc;
    int          cur;
    int          cyc = 0;
    int          checks = 0, errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    upsample_stream_nd #(.DATA_WIDTH(16), .IN_WIDTH(2), .IN_HEIGHT(2), .CHANNELS(1), .STRIDE(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .data_in(data_in), .ready_in(rdy_a),
        .valid_out(va), .data_out(da), .ready_out(ready_out)
`ifdef UPSAMPLE_FRAME_LAST_EN
        , .last_out(la)
`endif
    );
    upsample_stream_nd #(.DATA_WIDTH(16), .IN_WIDTH(2), .IN_HEIGHT(1), .CHANNELS(2), .STRIDE(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .data_in(data_in), .ready_in(rdy_b),
        .valid_out(vb), .data_out(db), .ready_out(ready_out)
`ifdef UPSAMPLE_FRAME_LAST_EN
        , .last_out(lb)
`endif
    );
    upsample_stream_nd #(.DATA_WIDTH(16), .IN_WIDTH(3), .IN_HEIGHT(2), .CHANNELS(1), .STRIDE(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .data_in(data_in), .ready_in(rdy_c),
        .valid_out(vc), .data_out(dc), .ready_out(ready_out)
`ifdef UPSAMPLE_FRAME_LAST_EN
        , .last_out(lc)
`endif
    );

`ifndef UPSAMPLE_FRAME_LAST_EN
    assign la = 1'b0;
    assign lb = 1'b0;
    assign lc = 1'b0;
`endif

    logic        rdy, vout, lst;
    logic [15:0] dout;
    assign rdy  = cur == 0 ? rdy_a : cur == 1 ? rdy_b : rdy_c;
    assign vout = cur == 0 ? va : cur == 1 ? vb : vc;
    assign dout = cur == 0 ? da : cur == 1 ? db : dc;
    assign lst  = cur == 0 ? la : cur == 1 ? lb : lc;

    logic [15:0] stim[$];
    logic [16:0] sb[$];
    logic [15:0] obs_d[$];
    logic        obs_l[$];
    int          obs_c[$];
    int          acc_c[$];
    int          drops, hold_bad;
    bit          abort, done;

    task automatic push_frame(input int w, input int h, input int c, input int s, input int off);
        int total, idx;
        logic [15:0] v;
        total = h * s * w * s * c;
        idx = 0;
        for (int y = 0; y < h; y++)
            for (int r = 0; r < s; r++)
                for (int x = 0; x < w; x++)
                    for (int k = 0; k < s; k++)
                        for (int ch = 0; ch < c; ch++) begin
                            v = (r == 0 && k == 0) ? stim[off + (y * w + x) * c + ch] : 16'd0;
                            sb.push_back({idx == total - 1, v});
                            idx++;
                        end
    endtask

    task automatic drive();
        bit acc;
        drops = 0;
        acc_c.delete();
        foreach (stim[i]) begin
            valid_in = 1'b1;
            data_in  = stim[i];
            acc = 1'b0;
            for (int t = 0; t < 300 && !acc && !abort; t++) begin
                @(negedge clk);
                if (abort) break;
                if (!rdy) drops++;
                if (rdy) begin
                    acc = 1'b1;
                    acc_c.push_back(cyc);
                end
                @(posedge clk);
                #1;
            end
            if (abort) break;
        end
        valid_in = 1'b0;
    endtask

    task automatic capture(input int n, input int budget);
        bit stall;
        logic [15:0] pd;
        obs_d.delete();
        obs_l.delete();
        obs_c.delete();
        hold_bad = 0;
        stall = 1'b0;
        pd = '0;
        for (int t = 0; t < budget && obs_d.size() < n; t++) begin
            @(negedge clk);
            if (stall && (vout !== 1'b1 || dout !== pd)) hold_bad++;
            stall = vout && !ready_out;
            pd = dout;
            if (vout && ready_out) begin
                obs_d.push_back(dout);
                obs_l.push_back(lst);
                obs_c.push_back(cyc);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        valid_in = 1'b0;
        data_in = '0;
        ready_out = 1'b1;
        abort = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({va, vb, vc} !== 3'b000) begin
            errors++;
            $display("FAIL reset_valid: got %b expected 000", {va, vb, vc});
        end
        checks++;
        if ({da, db, dc} !== 48'd0) begin
            errors++;
            $display("FAIL reset_data: got %h expected 0", {da, db, dc});
        end
        checks++;
        if ({rdy_a, rdy_b, rdy_c} !== 3'b111) begin
            errors++;
            $display("FAIL reset_ready_in: got %b expected 111", {rdy_a, rdy_b, rdy_c});
        end
        checks++;
        if ({la, lb, lc} !== 3'b000) begin
            errors++;
            $display("FAIL reset_last: got %b expected 000", {la, lb, lc});
        end
    endtask

    task automatic test_stride2();
        logic [16:0] e;
        cur = 0;
        do_reset();
        stim = '{16'd1, 16'd2, 16'd3, 16'd4};
        sb.delete();
        push_frame(2, 2, 1, 2, 0);
        fork
            drive();
            capture(16, 300);
        join
        checks++;
        if (obs_d.size() != 16) begin
            errors++;
            $display("FAIL s2_count: got %0d beats expected 16", obs_d.size());
        end
        foreach (obs_d[i]) begin
            if (sb.size() == 0) break;
            e = sb.pop_front();
            checks++;
            if (obs_d[i] !== e[15:0]) begin
                errors++;
                $display("FAIL s2_data[%0d]: got %0d expected %0d", i, $signed(obs_d[i]), $signed(e[15:0]));
            end
`ifdef UPSAMPLE_FRAME_LAST_EN
            checks++;
            if (obs_l[i] !== e[16]) begin
                errors++;
                $display("FAIL s2_last[%0d]: got %b expected %b", i, obs_l[i], e[16]);
            end
`endif
        end
        checks++;
        if (obs_c.size() == 0 || acc_c.size() == 0 || obs_c[0] != acc_c[0] + 1) begin
            errors++;
            $display("FAIL s2_latency: got out cycle %0d for accept cycle %0d, expected +1",
                     obs_c.size() ? obs_c[0] : -1, acc_c.size() ? acc_c[0] : -1);
        end
    endtask

    task automatic test_channels();
        logic [16:0] e;
        cur = 1;
        do_reset();
        stim = '{16'd5, 16'hFFFA, 16'd7, 16'd8};
        sb.delete();
        push_frame(2, 1, 2, 2, 0);
        fork
            drive();
            capture(16, 300);
        join
        checks++;
        if (obs_d.size() != 16) begin
            errors++;
            $display("FAIL ch_count: got %0d beats expected 16", obs_d.size());
        end
        foreach (obs_d[i]) begin
            if (sb.size() == 0) break;
            e = sb.pop_front();
            checks++;
            if (obs_d[i] !== e[15:0]) begin
                errors++;
                $display("FAIL ch_data[%0d]: got %0d expected %0d", i, $signed(obs_d[i]), $signed(e[15:0]));
            end
`ifdef UPSAMPLE_FRAME_LAST_EN
            checks++;
            if (obs_l[i] !== e[16]) begin
                errors++;
                $display("FAIL ch_last[%0d]: got %b expected %b", i, obs_l[i], e[16]);
            end
`endif
        end
    endtask

    task automatic test_passthrough();
        logic [16:0] e;
        cur = 2;
        do_reset();
        stim = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6};
        sb.delete();
        push_frame(3, 2, 1, 1, 0);
        fork
            drive();
            capture(6, 200);
        join
        checks++;
        if (obs_d.size() != 6) begin
            errors++;
            $display("FAIL pt_count: got %0d beats expected 6", obs_d.size());
        end
        foreach (obs_d[i]) begin
            if (sb.size() == 0) break;
            e = sb.pop_front();
            checks++;
            if (obs_d[i] !== e[15:0]) begin
                errors++;
                $display("FAIL pt_data[%0d]: got %0d expected %0d", i, obs_d[i], e[15:0]);
            end
`ifdef UPSAMPLE_FRAME_LAST_EN
            checks++;
            if (obs_l[i] !== e[16]) begin
                errors++;
                $display("FAIL pt_last[%0d]: got %b expected %b", i, obs_l[i], e[16]);
            end
`endif
        end
        checks++;
        if (drops != 0) begin
            errors++;
            $display("FAIL pt_ready_in: got %0d stalled cycles expected 0", drops);
        end
        checks++;
        if (obs_c.size() != 6 || obs_c[5] - obs_c[0] != 5) begin
            errors++;
            $display("FAIL pt_throughput: got span %0d expected 5",
                     obs_c.size() == 6 ? obs_c[5] - obs_c[0] : -1);
        end
    endtask

    task automatic test_backpressure();
        logic [16:0] e;
        cur = 0;
        do_reset();
        stim = '{16'd1, 16'd2, 16'd3, 16'd4};
        sb.delete();
        push_frame(2, 2, 1, 2, 0);
        done = 1'b0;
        fork
            drive();
            begin
                capture(16, 400);
                done = 1'b1;
            end
            while (!done) begin
                @(posedge clk);
                #1;
                ready_out = ~ready_out;
            end
        join
        ready_out = 1'b1;
        checks++;
        if (obs_d.size() != 16) begin
            errors++;
            $display("FAIL bp_count: got %0d beats expected 16", obs_d.size());
        end
        foreach (obs_d[i]) begin
            if (sb.size() == 0) break;
            e = sb.pop_front();
            checks++;
            if (obs_d[i] !== e[15:0]) begin
                errors++;
                $display("FAIL bp_data[%0d]: got %0d expected %0d", i, obs_d[i], e[15:0]);
            end
        end
        checks++;
        if (hold_bad != 0) begin
            errors++;
            $display("FAIL bp_hold: got %0d changed stalled beats expected 0", hold_bad);
        end
    endtask

    task automatic test_reset_mid();
        logic [16:0] e;
        cur = 0;
        do_reset();
        stim = '{16'd1, 16'd2, 16'd3, 16'd4};
        sb.delete();
        push_frame(2, 2, 1, 2, 0);
        fork
            drive();
            begin
                capture(3, 100);
                abort = 1'b1;
                rst_n = 1'b0;
                @(posedge clk);
                #1;
                checks++;
                if (vout !== 1'b0) begin
                    errors++;
                    $display("FAIL mid_reset_valid: got %b expected 0", vout);
                end
                rst_n = 1'b1;
            end
        join
        foreach (obs_d[i]) begin
            e = sb.pop_front();
            checks++;
            if (obs_d[i] !== e[15:0]) begin
                errors++;
                $display("FAIL mid_pre[%0d]: got %0d expected %0d", i, obs_d[i], e[15:0]);
            end
        end
        abort = 1'b0;
        sb.delete();
        push_frame(2, 2, 1, 2, 0);
        fork
            drive();
            capture(16, 300);
        join
        checks++;
        if (obs_d.size() != 16) begin
            errors++;
            $display("FAIL mid_count: got %0d beats expected 16", obs_d.size());
        end
        foreach (obs_d[i]) begin
            if (sb.size() == 0) break;
            e = sb.pop_front();
            checks++;
            if (obs_d[i] !== e[15:0]) begin
                errors++;
                $display("FAIL mid_data[%0d]: got %0d expected %0d", i, obs_d[i], e[15:0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [16:0] e;
        cur = 0;
        do_reset();
        stim = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
        sb.delete();
        push_frame(2, 2, 1, 2, 0);
        push_frame(2, 2, 1, 2, 4);
        fork
            drive();
            capture(32, 400);
        join
        checks++;
        if (obs_d.size() != 32) begin
            errors++;
            $display("FAIL b2b_count: got %0d beats expected 32", obs_d.size());
        end
        foreach (obs_d[i]) begin
            if (sb.size() == 0) break;
            e = sb.pop_front();
            checks++;
            if (obs_d[i] !== e[15:0]) begin
                errors++;
                $display("FAIL b2b_data[%0d]: got %0d expected %0d", i, obs_d[i], e[15:0]);
            end
`ifdef UPSAMPLE_FRAME_LAST_EN
            checks++;
            if (obs_l[i] !== e[16]) begin
                errors++;
                $display("FAIL b2b_last[%0d]: got %b expected %b", i, obs_l[i], e[16]);
            end
`endif
        end
        checks++;
        if (obs_c.size() != 32 || obs_c[31] - obs_c[0] != 31) begin
            errors++;
            $display("FAIL b2b_throughput: got span %0d expected 31",
                     obs_c.size() == 32 ? obs_c[31] - obs_c[0] : -1);
        end
    endtask

    initial begin
        cur = 0;
        test_reset();
        test_stride2();
        test_channels();
        test_passthrough();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
